cpu_clock_sequencer: RTL

- Generates the CPU clock `cpu_clock` that drives the controller and datapath from the board clock.
- Supports free-run and single-step modes.
- Stops the CPU when the controller raises end_sq.
- Counts executed CPU cycles for the monitor, skipping cycles the controller flags with pause_cc.

---
 rtl/cpu_clock_sequencer_pkg.sv | 21 ++
 rtl/cpu_clock_sequencer_if.sv | 27 ++
 rtl/cpu_clock_sequencer_input_debouncer.sv | 40 ++++
 rtl/cpu_clock_sequencer.sv | 102 ++++++++++
 4 files changed

// File: rtl/cpu_clock_sequencer_pkg.sv
// Shared constants for the CPU clock sequencer: FSM state encodings and the
// default timing parameters used by the monitor top level and its benches.
package cpu_clock_sequencer_pkg;

  localparam logic [2:0] SEQ_IDLE    = 3'd0;
  localparam logic [2:0] SEQ_STEP_HI = 3'd1;
  localparam logic [2:0] SEQ_STEP_LO = 3'd2;
  localparam logic [2:0] SEQ_RUN_HI  = 3'd3;
  localparam logic [2:0] SEQ_RUN_LO  = 3'd4;
  localparam logic [2:0] SEQ_HALTED  = 3'd5;

  localparam int unsigned DEFAULT_DIV      = 25000000;
  localparam int unsigned DEFAULT_DEBOUNCE = 500000;
  localparam int unsigned DEFAULT_CNT_W    = 16;

  // cpu_clock is high exactly in the two HI states
  function automatic logic seq_is_hi(input logic [2:0] s);
    return (s == SEQ_STEP_HI) || (s == SEQ_RUN_HI);
  endfunction

endpackage

// File: rtl/cpu_clock_sequencer_if.sv
// Board-side bundle of the CPU clock sequencer.
//   master: drives run_sw, step_btn, end_sq, pause_cc; observes the outputs
//   slave : the sequencer; drives cpu_clock, cycle_count, running, halted
interface cpu_clock_sequencer_if
  import cpu_clock_sequencer_pkg::*;
#(
  parameter int unsigned CNT_W = DEFAULT_CNT_W
);
  logic             run_sw;
  logic             step_btn;
  logic             end_sq;
  logic             pause_cc;
  logic             cpu_clock;
  logic [CNT_W-1:0] cycle_count;
  logic             running;
  logic             halted;

  modport master (
    output run_sw, step_btn, end_sq, pause_cc,
    input  cpu_clock, cycle_count, running, halted
  );

  modport slave (
    input  run_sw, step_btn, end_sq, pause_cc,
    output cpu_clock, cycle_count, running, halted
  );
endinterface

// File: rtl/cpu_clock_sequencer_input_debouncer.sv
// 2-FF synchronizer followed by a stability-counter debouncer.
//   clock, reset_n : board clock, async active-low reset
//   din            : raw asynchronous input
//   dout           : debounced level, changes only after the synchronized
//                    input has held the new value for DEBOUNCE clocks
module input_debouncer
  import cpu_clock_sequencer_pkg::*;
#(
  parameter int unsigned DEBOUNCE = DEFAULT_DEBOUNCE
) (
  input  logic clock,
  input  logic reset_n,
  input  logic din,
  output logic dout
);
  localparam int unsigned CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] stable_cnt;

  // counter tracks how long the synchronized value has disagreed with dout
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q     <= 2'b00;
      stable_cnt <= '0;
      dout       <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], din};
      if (sync_q[1] == dout) begin
        stable_cnt <= '0;
      end else if (stable_cnt == CNT_LAST) begin
        dout       <= sync_q[1];
        stable_cnt <= '0;
      end else begin
        stable_cnt <= stable_cnt + CW'(1);
      end
    end
  end
endmodule

// File: rtl/cpu_clock_sequencer.sv
// Generates the CPU clock from the board clock in free-run or single-step
// mode, halts on end_sq and counts executed (non-paused) CPU cycles.
//   clock, reset_n : board clock, async active-low reset
//   bus (slave)    : run_sw, step_btn, end_sq, pause_cc in;
//                    cpu_clock, cycle_count, running, halted out
module cpu_clock_sequencer
  import cpu_clock_sequencer_pkg::*;
#(
  parameter int unsigned DIV      = DEFAULT_DIV,
  parameter int unsigned DEBOUNCE = DEFAULT_DEBOUNCE,
  parameter int unsigned CNT_W    = DEFAULT_CNT_W
) (
  input  logic                 clock,
  input  logic                 reset_n,
  cpu_clock_sequencer_if.slave bus
);
  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0]    PHASE_LAST = PW'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  logic             run_db;
  logic             step_db;
  logic             step_db_q;
  logic             step_req;
  logic [2:0]       state, state_nxt;
  logic [PW-1:0]    phase, phase_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic             phase_last;

  input_debouncer #(.DEBOUNCE(DEBOUNCE)) u_run_db (
    .clock(clock), .reset_n(reset_n), .din(bus.run_sw), .dout(run_db)
  );

  input_debouncer #(.DEBOUNCE(DEBOUNCE)) u_step_db (
    .clock(clock), .reset_n(reset_n), .din(bus.step_btn), .dout(step_db)
  );

  assign step_req   = step_db & ~step_db_q;
  assign phase_last = (phase == PHASE_LAST);

  // next state, phase timer and cycle counter
  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    count_nxt = count;
    case (state)
      SEQ_IDLE: begin
        phase_nxt = '0;
        if (run_db)        state_nxt = SEQ_RUN_HI;
        else if (step_req) state_nxt = SEQ_STEP_HI;
      end
      SEQ_STEP_HI, SEQ_RUN_HI: begin
        if (phase_last) begin
          phase_nxt = '0;
          state_nxt = (state == SEQ_STEP_HI) ? SEQ_STEP_LO : SEQ_RUN_LO;
          if (!bus.pause_cc && (count != CNT_MAX)) count_nxt = count + CNT_W'(1);
        end else begin
          phase_nxt = phase + PW'(1);
        end
      end
      SEQ_STEP_LO, SEQ_RUN_LO: begin
        if (phase_last) begin
          phase_nxt = '0;
          // end_sq now reflects the controller after this cycle's falling edge
          if (bus.end_sq)  state_nxt = SEQ_HALTED;
          else if (run_db) state_nxt = SEQ_RUN_HI;
          else             state_nxt = SEQ_IDLE;
        end else begin
          phase_nxt = phase + PW'(1);
        end
      end
      SEQ_HALTED: phase_nxt = '0;
      default: begin
        state_nxt = SEQ_IDLE;
        phase_nxt = '0;
      end
    endcase
  end

  // outputs registered from the next state: glitch-free, one-clock latency
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state         <= SEQ_IDLE;
      phase         <= '0;
      count         <= '0;
      step_db_q     <= 1'b0;
      bus.cpu_clock <= 1'b0;
      bus.running   <= 1'b0;
      bus.halted    <= 1'b0;
    end else begin
      state         <= state_nxt;
      phase         <= phase_nxt;
      count         <= count_nxt;
      step_db_q     <= step_db;
      bus.cpu_clock <= seq_is_hi(state_nxt);
      bus.running   <= (state_nxt == SEQ_RUN_HI) || (state_nxt == SEQ_RUN_LO);
      bus.halted    <= (state_nxt == SEQ_HALTED);
    end
  end

  assign bus.cycle_count = count;
endmodule
